// File: rtl/lcd_spi_monitor_if.sv
// Pin-side and decoded-event signals of the ST7735 SPI monitor.
// slave = the monitor itself; master = whoever drives the pins and consumes the events.
interface lcd_spi_monitor_if;
   logic        lcd_cs;
   logic        lcd_dc;
   logic        lcd_sclk;
   logic        lcd_mosi;
   logic [8:0]  rx_data;
   logic        rx_valid;
   logic        cmd_valid;
   logic [7:0]  cmd_code;
   logic        pix_valid;
   logic [7:0]  pix_x;
   logic [7:0]  pix_y;
   logic [15:0] pix_color;
   logic        frame_err;

   modport slave (
      input  lcd_cs, lcd_dc, lcd_sclk, lcd_mosi,
      output rx_data, rx_valid, cmd_valid, cmd_code,
      output pix_valid, pix_x, pix_y, pix_color, frame_err
   );

   modport master (
      output lcd_cs, lcd_dc, lcd_sclk, lcd_mosi,
      input  rx_data, rx_valid, cmd_valid, cmd_code,
      input  pix_valid, pix_x, pix_y, pix_color, frame_err
   );
endinterface

// File: rtl/lcd_spi_monitor.sv
// Passive ST7735 SPI listener: rebuilds {dc,byte} words and decodes CASET/RASET/RAMWR
// into per-pixel (x,y,color) events.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | no tracked command; data bytes ignored
// S_CASET    | collecting column window bytes (idx 0..3)
// S_RASET    | collecting row window bytes (idx 0..3)
// S_RAMWR_HI | RAMWR active, waiting for pixel high byte
// S_RAMWR_LO | RAMWR active, high byte held, waiting for low byte
module lcd_spi_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int X_MAX       = 127,
   parameter int Y_MAX       = 159
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   lcd_spi_monitor_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CASET,
      S_RASET,
      S_RAMWR_HI,
      S_RAMWR_LO
   } state_t;

   localparam logic [7:0] XE_RST = 8'(X_MAX);
   localparam logic [7:0] YE_RST = 8'(Y_MAX);

   logic [SYNC_STAGES-1:0] cs_sync, dc_sync, sclk_sync, mosi_sync;
   logic cs_s, dc_s, sclk_s, mosi_s;
   logic cs_prev, sclk_prev;
   logic cs_rise, sclk_rise;
   logic [6:0] sr;
   logic [2:0] bit_cnt;
   logic       byte_done;
   logic [8:0] byte_word;
   logic       frame_err_q;

   // Synchronisers keep tracking the pins through reset so no false edge follows it.
   always_ff @(posedge sys_clk) begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.lcd_cs};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], bus.lcd_dc};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.lcd_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.lcd_mosi};
   end

   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign dc_s      = dc_sync[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign cs_rise   = cs_s & ~cs_prev;
   assign sclk_rise = sclk_s & ~sclk_prev;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cs_prev     <= cs_s;
         sclk_prev   <= sclk_s;
         sr          <= '0;
         bit_cnt     <= '0;
         byte_done   <= 1'b0;
         byte_word   <= '0;
         frame_err_q <= 1'b0;
      end else begin
         cs_prev     <= cs_s;
         sclk_prev   <= sclk_s;
         byte_done   <= 1'b0;
         frame_err_q <= cs_rise && (bit_cnt != 3'd0);
         if (cs_s) begin
            bit_cnt <= '0;
         end else if (sclk_rise) begin
            sr      <= {sr[5:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               byte_done <= 1'b1;
               byte_word <= {dc_s, sr, mosi_s};
            end
         end
      end
   end

   state_t      state, state_n;
   logic [1:0]  idx, idx_n;
   logic [7:0]  xs, xs_n, xe, xe_n, ys, ys_n, ye, ye_n;
   logic [7:0]  cur_x, cur_x_n, cur_y, cur_y_n;
   logic [7:0]  hi, hi_n;
   logic [8:0]  rx_data_q, rx_data_n;
   logic        rx_valid_q, rx_valid_n;
   logic        cmd_valid_q, cmd_valid_n;
   logic [7:0]  cmd_code_q, cmd_code_n;
   logic        pix_valid_q, pix_valid_n;
   logic [7:0]  pix_x_q, pix_x_n, pix_y_q, pix_y_n;
   logic [15:0] pix_color_q, pix_color_n;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state       <= S_IDLE;
         idx         <= '0;
         xs          <= '0;
         xe          <= XE_RST;
         ys          <= '0;
         ye          <= YE_RST;
         cur_x       <= '0;
         cur_y       <= '0;
         hi          <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         cmd_valid_q <= 1'b0;
         cmd_code_q  <= '0;
         pix_valid_q <= 1'b0;
         pix_x_q     <= '0;
         pix_y_q     <= '0;
         pix_color_q <= '0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         xs          <= xs_n;
         xe          <= xe_n;
         ys          <= ys_n;
         ye          <= ye_n;
         cur_x       <= cur_x_n;
         cur_y       <= cur_y_n;
         hi          <= hi_n;
         rx_data_q   <= rx_data_n;
         rx_valid_q  <= rx_valid_n;
         cmd_valid_q <= cmd_valid_n;
         cmd_code_q  <= cmd_code_n;
         pix_valid_q <= pix_valid_n;
         pix_x_q     <= pix_x_n;
         pix_y_q     <= pix_y_n;
         pix_color_q <= pix_color_n;
      end
   end

   // Decode on byte_done so cmd/pix pulses land in the same cycle as rx_valid.
   always_comb begin
      state_n     = state;
      idx_n       = idx;
      xs_n        = xs;
      xe_n        = xe;
      ys_n        = ys;
      ye_n        = ye;
      cur_x_n     = cur_x;
      cur_y_n     = cur_y;
      hi_n        = hi;
      rx_data_n   = rx_data_q;
      rx_valid_n  = 1'b0;
      cmd_valid_n = 1'b0;
      cmd_code_n  = cmd_code_q;
      pix_valid_n = 1'b0;
      pix_x_n     = pix_x_q;
      pix_y_n     = pix_y_q;
      pix_color_n = pix_color_q;
      if (byte_done) begin
         rx_valid_n = 1'b1;
         rx_data_n  = byte_word;
         if (!byte_word[8]) begin
            cmd_valid_n = 1'b1;
            cmd_code_n  = byte_word[7:0];
            case (byte_word[7:0])
               8'h2A: begin
                  state_n = S_CASET;
                  idx_n   = 2'd0;
               end
               8'h2B: begin
                  state_n = S_RASET;
                  idx_n   = 2'd0;
               end
               8'h2C: begin
                  state_n = S_RAMWR_HI;
                  cur_x_n = xs;
                  cur_y_n = ys;
               end
               default: state_n = S_IDLE;
            endcase
         end else begin
            case (state)
               S_CASET, S_RASET: begin
                  if (idx == 2'd1) begin
                     if (state == S_CASET) xs_n = byte_word[7:0];
                     else                  ys_n = byte_word[7:0];
                  end else if (idx == 2'd3) begin
                     if (state == S_CASET) xe_n = byte_word[7:0];
                     else                  ye_n = byte_word[7:0];
                     state_n = S_IDLE;
                  end
                  idx_n = idx + 2'd1;
               end
               S_RAMWR_HI: begin
                  hi_n    = byte_word[7:0];
                  state_n = S_RAMWR_LO;
               end
               S_RAMWR_LO: begin
                  pix_valid_n = 1'b1;
                  pix_color_n = {hi, byte_word[7:0]};
                  pix_x_n     = cur_x;
                  pix_y_n     = cur_y;
                  // Inverted windows (start > end) collapse to a single column/row.
                  if (cur_x >= xe) begin
                     cur_x_n = xs;
                     cur_y_n = (cur_y >= ye) ? ys : cur_y + 8'd1;
                  end else begin
                     cur_x_n = cur_x + 8'd1;
                  end
                  state_n = S_RAMWR_HI;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.cmd_valid = cmd_valid_q;
   assign bus.cmd_code  = cmd_code_q;
   assign bus.pix_valid = pix_valid_q;
   assign bus.pix_x     = pix_x_q;
   assign bus.pix_y     = pix_y_q;
   assign bus.pix_color = pix_color_q;
   assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_lcd_spi_monitor.sv
// Bench for lcd_spi_monitor: directed ST7735 sequences plus random traffic, scored against
// a window/pixel-index reference model.
module tb_lcd_spi_monitor;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   always #5 sys_clk = ~sys_clk;

   lcd_spi_monitor_if bus ();

   lcd_spi_monitor #(.SYNC_STAGES(2), .X_MAX(127), .Y_MAX(159)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: window registers, command context, and data count since the last command.
   logic [8:0]  exp_rx[$];
   logic [7:0]  exp_cmd[$];
   logic [31:0] exp_pix[$];
   int fe_exp = 0;
   int fe_seen = 0;
   int m_cmd, m_n, m_xs, m_xe, m_ys, m_ye, m_hi;

   function automatic void model_reset();
      exp_rx.delete();
      exp_cmd.delete();
      exp_pix.delete();
      m_cmd = 0; m_n = 0; m_hi = 0;
      m_xs = 0; m_xe = 127; m_ys = 0; m_ye = 159;
   endfunction

   function automatic void model_byte(input bit dc, input logic [7:0] b);
      int p, w, h, x, y;
      exp_rx.push_back({dc, b});
      if (!dc) begin
         exp_cmd.push_back(b);
         m_cmd = int'(b);
         m_n = 0;
      end else begin
         m_n++;
         if (m_cmd == 'h2A) begin
            if (m_n == 2) m_xs = int'(b);
            if (m_n == 4) m_xe = int'(b);
         end else if (m_cmd == 'h2B) begin
            if (m_n == 2) m_ys = int'(b);
            if (m_n == 4) m_ye = int'(b);
         end else if (m_cmd == 'h2C) begin
            if (m_n % 2 == 1) m_hi = int'(b);
            else begin
               p = m_n / 2 - 1;
               w = (m_xs <= m_xe) ? m_xe - m_xs + 1 : 1;
               h = (m_ys <= m_ye) ? m_ye - m_ys + 1 : 1;
               x = m_xs + p % w;
               y = m_ys + (p / w) % h;
               exp_pix.push_back({8'(x), 8'(y), 8'(m_hi), b});
            end
         end
      end
   endfunction

   // Scoreboard side: sample on the falling edge, away from the DUT's active edge.
   always @(negedge sys_clk) begin
      if (bus.frame_err) fe_seen++;
      if (bus.rx_valid) begin
         if (exp_rx.size() == 0) chk("rx_unexpected", {23'd0, bus.rx_data}, 32'h1_0000);
         else chk("rx_data", {23'd0, bus.rx_data}, {23'd0, exp_rx.pop_front()});
      end
      if (bus.cmd_valid) begin
         chk("cmd_with_rx", {31'd0, bus.rx_valid}, 32'd1);
         if (exp_cmd.size() == 0) chk("cmd_unexpected", {24'd0, bus.cmd_code}, 32'h1_0000);
         else chk("cmd_code", {24'd0, bus.cmd_code}, {24'd0, exp_cmd.pop_front()});
      end
      if (bus.pix_valid) begin
         chk("pix_with_rx", {31'd0, bus.rx_valid}, 32'd1);
         if (exp_pix.size() == 0) chk("pix_unexpected", {bus.pix_x, bus.pix_y, bus.pix_color}, 32'hFFFF_FFFF);
         else chk("pix", {bus.pix_x, bus.pix_y, bus.pix_color}, exp_pix.pop_front());
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge sys_clk);
   endtask

   task automatic spi_bits(input bit dc, input logic [7:0] b, input int nbits);
      if (bus.lcd_cs) begin
         bus.lcd_cs = 1'b0;
         wait_clks(2);
      end
      bus.lcd_dc = dc;
      for (int i = 0; i < nbits; i++) begin
         bus.lcd_mosi = b[7-i];
         bus.lcd_sclk = 1'b0;
         wait_clks($urandom_range(2, 4));
         bus.lcd_sclk = 1'b1;
         wait_clks($urandom_range(2, 4));
      end
      bus.lcd_sclk = 1'b0;
      wait_clks(2);
   endtask

   task automatic cs_high();
      bus.lcd_cs = 1'b1;
      wait_clks(3);
   endtask

   task automatic send_byte(input bit dc, input logic [7:0] b);
      model_byte(dc, b);
      spi_bits(dc, b, 8);
   endtask

   task automatic send_partial(input int nbits);
      fe_exp++;
      spi_bits(1'($urandom_range(0, 1)), 8'($urandom), nbits);
      cs_high();
   endtask

   task automatic drain(input string tag);
      int t = 0;
      while ((exp_rx.size() != 0 || exp_cmd.size() != 0 || exp_pix.size() != 0) && t < 500) begin
         @(posedge sys_clk);
         t++;
      end
      wait_clks(8);
      chk({tag, "_drain"}, 32'(exp_rx.size() + exp_cmd.size() + exp_pix.size()), 32'd0);
      chk({tag, "_frame_err"}, 32'(fe_seen), 32'(fe_exp));
   endtask

   initial begin
      logic [15:0] colors [7];
      colors = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF, 16'h0000, 16'h1234, 16'hABCD};
      bus.lcd_cs = 1'b1;
      bus.lcd_dc = 1'b0;
      bus.lcd_sclk = 1'b0;
      bus.lcd_mosi = 1'b0;
      model_reset();

      // T1: reset state
      sys_rst = 1'b1;
      wait_clks(3);
      @(negedge sys_clk);
      chk("rst_rx_data", {23'd0, bus.rx_data}, 32'd0);
      chk("rst_strobes", {28'd0, bus.rx_valid, bus.cmd_valid, bus.pix_valid, bus.frame_err}, 32'd0);
      chk("rst_cmd_code", {24'd0, bus.cmd_code}, 32'd0);
      chk("rst_pix", {bus.pix_x, bus.pix_y, bus.pix_color}, 32'd0);
      sys_rst = 1'b0;
      wait_clks(2);

      // T2/T3: window setup then 7 pixels across a 3x2 window with frame wrap
      send_byte(0, 8'h2A);
      send_byte(1, 8'h00); send_byte(1, 8'h05); send_byte(1, 8'h00); send_byte(1, 8'h07);
      cs_high();
      send_byte(0, 8'h2B);
      send_byte(1, 8'h00); send_byte(1, 8'h02); send_byte(1, 8'h00); send_byte(1, 8'h03);
      send_byte(0, 8'h2C);
      foreach (colors[i]) begin
         send_byte(1, colors[i][15:8]);
         send_byte(1, colors[i][7:0]);
      end
      drain("t3");
      chk("t3_last_pix", {bus.pix_x, bus.pix_y, bus.pix_color}, 32'h0502_ABCD);

      // T4: aborted partial byte then a full RAMWR command
      spi_bits(1, 8'hA5, 5);
      fe_exp++;
      cs_high();
      send_byte(0, 8'h2C);
      drain("t4");
      chk("t4_rx_data", {23'd0, bus.rx_data}, 32'h02C);
      chk("t4_cmd_code", {24'd0, bus.cmd_code}, 32'h2C);

      // T5: command between hi and lo bytes discards the pixel; later data is ignored
      send_byte(1, 8'hAA);
      send_byte(0, 8'h00);
      send_byte(1, 8'h11);
      send_byte(1, 8'h22);
      drain("t5");

      // T6: reset in the middle of a byte, then a clean byte
      spi_bits(1, 8'hFF, 3);
      sys_rst = 1'b1;
      wait_clks(3);
      model_reset();
      sys_rst = 1'b0;
      wait_clks(2);
      send_byte(1, 8'h55);
      drain("t6");
      chk("t6_rx_data", {23'd0, bus.rx_data}, 32'h155);

      // Random traffic: commands, window params (small so wraps occur), pixels, partial frames
      for (int k = 0; k < 300; k++) begin
         int r;
         logic [7:0] b;
         r = $urandom_range(0, 99);
         if (r < 8) begin
            send_partial($urandom_range(1, 7));
         end else if (r < 33) begin
            case ($urandom_range(0, 3))
               0: b = 8'h2A;
               1: b = 8'h2B;
               2: b = 8'h2C;
               default: b = 8'($urandom);
            endcase
            send_byte(0, b);
         end else begin
            b = 8'($urandom);
            if ((m_cmd == 'h2A || m_cmd == 'h2B) && m_n < 4 && (m_n % 2 == 1))
               b = 8'($urandom_range(0, 12));
            send_byte(1, b);
         end
         if ($urandom_range(0, 4) == 0) cs_high();
      end
      cs_high();
      drain("rand");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #20_000_000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
